// File: rtl/trig_generator_pkg.sv
// Shared constants for the trigger decoder: bus widths, the trigger
// register address and the wdata bit positions of the two clear triggers.
package trig_pkg;

  localparam int              DEF_ADDR_W       = 12;
  localparam int              DEF_DATA_W       = 8;
  localparam logic [11:0]     DEF_TRIG_ADDR    = 12'h00C;
  localparam int              DEF_I2SI_OVR_BIT = 0;
  localparam int              DEF_I2SO_UDR_BIT = 1;

endpackage

// File: rtl/trig_generator_if.sv
// Register write bus seen by the trigger decoder: one write per cycle
// in which xfc is high; address/wdata are only meaningful while xfc=1.
interface trig_bus_if
  import trig_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic              xfc;

  modport master (output address, output wdata, output xfc);
  modport slave  (input  address, input  wdata, input  xfc);

endinterface

// File: rtl/trig_generator_pulse.sv
// One-cycle pulse flop: registers the fire request so the output is high
// for the single cycle after the edge that saw it. Cleared asynchronously
// while rst is low.
module trig_pulse (
  input  logic clk,
  input  logic rst,
  input  logic fire,
  output logic pulse_q
);

  logic pulse_d;

  // Next pulse value is simply this cycle's fire request.
  always_comb begin
    pulse_d = fire;
  end

  // Pulse register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
    end
  end

endmodule

// File: rtl/trig_generator.sv
// Trigger decoder: turns a write to the write-only trigger register into
// single-cycle clear pulses for the I2S-in overrun and I2S-out underrun
// sticky flags. Only the address decode lives here; the pulses come from
// two trig_pulse flops.
// Optional build macro: TRIG_GENERATOR_ALIGN_CHECK_EN -- when defined, a
// write only hits if its address is word aligned (address[1:0]==2'b00),
// so a misaligned TRIG_ADDR can never trigger.
module trig_generator
  import trig_pkg::*;
#(
  parameter int              ADDR_W       = DEF_ADDR_W,
  parameter int              DATA_W       = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] TRIG_ADDR  = DEF_TRIG_ADDR,
  parameter int              I2SI_OVR_BIT = DEF_I2SI_OVR_BIT,
  parameter int              I2SO_UDR_BIT = DEF_I2SO_UDR_BIT
) (
  input  logic           clk,
  input  logic           rst,
  trig_bus_if.slave      bus,
  output logic           trig_i2si_fifo_overrun_clr,
  output logic           trig_i2so_fifo_underrun_clr
);

  logic hit_s;
  logic fire_i2si_s;
  logic fire_i2so_s;
  logic unused_wdata_s;

  // Only two wdata bits matter; fold the whole word here so the rest is
  // visibly intentional rather than forgotten.
  assign unused_wdata_s = ^bus.wdata;

  // Decode a trigger-register write and pick out the two trigger bits.
  always_comb begin
    hit_s = bus.xfc && (bus.address == TRIG_ADDR);
`ifdef TRIG_GENERATOR_ALIGN_CHECK_EN
    if (bus.address[1:0] != 2'b00) begin
      hit_s = 1'b0;
    end else begin
      hit_s = hit_s;
    end
`endif
    fire_i2si_s = hit_s && bus.wdata[I2SI_OVR_BIT];
    fire_i2so_s = hit_s && bus.wdata[I2SO_UDR_BIT];
  end

  trig_pulse u_i2si_ovr_clr (
    .clk     (clk),
    .rst     (rst),
    .fire    (fire_i2si_s),
    .pulse_q (trig_i2si_fifo_overrun_clr)
  );

  trig_pulse u_i2so_udr_clr (
    .clk     (clk),
    .rst     (rst),
    .fire    (fire_i2so_s),
    .pulse_q (trig_i2so_fifo_underrun_clr)
  );

endmodule

// File: tb/tb_trig_generator.sv
// Directed self-checking bench for trig_generator. Inputs change on the
// falling edge; outputs are sampled 1 time unit after the rising edge.
`timescale 1ns/1ps
module tb_trig_generator;

  logic clk;
  logic rst;
  logic i2si_clr;
  logic i2so_clr;
  logic mis_i2si_clr;
  logic mis_i2so_clr;

  int pass_cnt;
  int total_cnt;

  trig_bus_if #(.ADDR_W(12), .DATA_W(8)) bus ();

  trig_generator dut (
    .clk                         (clk),
    .rst                         (rst),
    .bus                         (bus),
    .trig_i2si_fifo_overrun_clr  (i2si_clr),
    .trig_i2so_fifo_underrun_clr (i2so_clr)
  );

  // Second instance with a misaligned trigger address for the alignment option.
  trig_generator #(.TRIG_ADDR(12'h00D)) dut_mis (
    .clk                         (clk),
    .rst                         (rst),
    .bus                         (bus),
    .trig_i2si_fifo_overrun_clr  (mis_i2si_clr),
    .trig_i2so_fifo_underrun_clr (mis_i2so_clr)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [11:0] a, input logic [7:0] d, input logic x);
    @(negedge clk);
    bus.address = a;
    bus.wdata   = d;
    bus.xfc     = x;
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(12'h00C, 8'hFF, (i % 2 == 0) ? 1'b1 : 1'b0);
      sample();
      total_cnt++;
      if ({i2si_clr, i2so_clr} !== 2'b00) begin
        $display("FAIL reset cyc%0d: got %b%b want 00", i, i2si_clr, i2so_clr);
      end else begin
        pass_cnt++;
      end
    end
    drive(12'h000, 8'h00, 1'b0);
    rst = 1'b1;
    sample();
  endtask

  task automatic test_sweep();
    logic [11:0] a;
    logic        e;
    for (int i = 0; i < 8; i++) begin
      a = 12'(i * 4);
      e = (a == 12'h00C);
      drive(a, 8'hFF, 1'b1);
      sample();
      total_cnt++;
      if ({i2si_clr, i2so_clr} !== {e, e}) begin
        $display("FAIL sweep addr=%h: got %b%b want %b%b", a, i2si_clr, i2so_clr, e, e);
      end else begin
        pass_cnt++;
      end
    end
    drive(12'h020, 8'hFF, 1'b0);
    sample();
    total_cnt++;
    if ({i2si_clr, i2so_clr} !== 2'b00) begin
      $display("FAIL sweep idle: got %b%b want 00", i2si_clr, i2so_clr);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic test_selective_bits();
    logic [7:0] d_tab [3] = '{8'h01, 8'h02, 8'hFC};
    logic [1:0] e_tab [3] = '{2'b10, 2'b01, 2'b00};
    for (int i = 0; i < 3; i++) begin
      drive(12'h00C, d_tab[i], 1'b1);
      sample();
      total_cnt++;
      if ({i2si_clr, i2so_clr} !== e_tab[i]) begin
        $display("FAIL selective wdata=%h: got %b%b want %b", d_tab[i], i2si_clr, i2so_clr, e_tab[i]);
      end else begin
        pass_cnt++;
      end
      drive(12'h000, 8'h00, 1'b0);
      sample();
      total_cnt++;
      if ({i2si_clr, i2so_clr} !== 2'b00) begin
        $display("FAIL selective_width wdata=%h: got %b%b want 00", d_tab[i], i2si_clr, i2so_clr);
      end else begin
        pass_cnt++;
      end
    end
  endtask

  task automatic test_strobe_gating();
    drive(12'h00C, 8'hFF, 1'b0);
    sample();
    total_cnt++;
    if ({i2si_clr, i2so_clr} !== 2'b00) begin
      $display("FAIL gating xfc0: got %b%b want 00", i2si_clr, i2so_clr);
    end else begin
      pass_cnt++;
    end
    drive(12'h10C, 8'hFF, 1'b1);
    sample();
    total_cnt++;
    if ({i2si_clr, i2so_clr} !== 2'b00) begin
      $display("FAIL gating addr10C: got %b%b want 00", i2si_clr, i2so_clr);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] e_tab [3] = '{2'b11, 2'b11, 2'b00};
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(12'h00C, 8'h03, 1'b1);
      else       drive(12'h000, 8'h00, 1'b0);
      sample();
      total_cnt++;
      if ({i2si_clr, i2so_clr} !== e_tab[i]) begin
        $display("FAIL b2b cyc%0d: got %b%b want %b", i, i2si_clr, i2so_clr, e_tab[i]);
      end else begin
        pass_cnt++;
      end
    end
  endtask

  task automatic test_async_reset();
    drive(12'h00C, 8'h01, 1'b1);
    sample();
    total_cnt++;
    if ({i2si_clr, i2so_clr} !== 2'b10) begin
      $display("FAIL async pre: got %b%b want 10", i2si_clr, i2so_clr);
    end else begin
      pass_cnt++;
    end
    #2 rst = 1'b0;
    #1;
    total_cnt++;
    if ({i2si_clr, i2so_clr} !== 2'b00) begin
      $display("FAIL async drop: got %b%b want 00", i2si_clr, i2so_clr);
    end else begin
      pass_cnt++;
    end
    drive(12'h00C, 8'h02, 1'b1);
    rst = 1'b1;
    sample();
    total_cnt++;
    if ({i2si_clr, i2so_clr} !== 2'b01) begin
      $display("FAIL async first_edge: got %b%b want 01", i2si_clr, i2so_clr);
    end else begin
      pass_cnt++;
    end
    drive(12'h000, 8'h00, 1'b0);
    sample();
  endtask

  task automatic test_align();
    logic [1:0] e;
`ifdef TRIG_GENERATOR_ALIGN_CHECK_EN
    e = 2'b00;
`else
    e = 2'b11;
`endif
    drive(12'h00D, 8'h03, 1'b1);
    sample();
    total_cnt++;
    if ({mis_i2si_clr, mis_i2so_clr} !== e) begin
      $display("FAIL align misaligned_hit: got %b%b want %b", mis_i2si_clr, mis_i2so_clr, e);
    end else begin
      pass_cnt++;
    end
    total_cnt++;
    if ({i2si_clr, i2so_clr} !== 2'b00) begin
      $display("FAIL align main_dut: got %b%b want 00", i2si_clr, i2so_clr);
    end else begin
      pass_cnt++;
    end
    drive(12'h000, 8'h00, 1'b0);
    sample();
  endtask

  initial begin
    pass_cnt    = 0;
    total_cnt   = 0;
    rst         = 1'b0;
    bus.address = 12'h000;
    bus.wdata   = 8'h00;
    bus.xfc     = 1'b0;
    test_reset();
    test_sweep();
    test_selective_bits();
    test_strobe_gating();
    test_back_to_back();
    test_async_reset();
    test_align();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/trig_generator.md
Name: trig_generator

Overview:
- Register-bus trigger decoder for the chip register block.
- Watches write transfers (address, wdata, xfc) and converts a write to the trigger register into single-cycle clear pulses for the I2S input FIFO overrun flag and the I2S output FIFO underrun flag.
- Sits beside the chip register file; outputs drive the sticky status-flag clear inputs in the I2S blocks.

Parameters:
- ADDR_W, 12, register address width.
- DATA_W, 8, write data width.
- TRIG_ADDR, 12'h00C, byte address of the write-only trigger register.
- I2SI_OVR_BIT, 0, wdata bit that fires trig_i2si_fifo_overrun_clr.
- I2SO_UDR_BIT, 1, wdata bit that fires trig_i2so_fifo_underrun_clr.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset; one clock domain; asynchronous assert, active-low (0 = reset).
- address  input  ADDR_W  register byte address, valid when xfc=1.
- wdata  input  DATA_W  write data, valid when xfc=1.
- xfc  input  1  write transfer strobe; one write per cycle in which it is high.
- trig_i2si_fifo_overrun_clr  output  1  one-cycle clear pulse, I2S-in FIFO overrun flag.
- trig_i2so_fifo_underrun_clr  output  1  one-cycle clear pulse, I2S-out FIFO underrun flag.

Behaviour:
- Both outputs are flops. Reset value 0; cleared immediately on rst=0, independent of clk.
- Hit condition: xfc=1 and address==TRIG_ADDR (full ADDR_W compare).
- On a rising clk edge with a hit:
  - trig_i2si_fifo_overrun_clr <= wdata[I2SI_OVR_BIT].
  - trig_i2so_fifo_underrun_clr <= wdata[I2SO_UDR_BIT].
- On any other edge, both outputs <= 0.
- Latency: pulse is high for the one cycle following the write edge.
- Pulse width is exactly one cycle per write. Back-to-back hits on consecutive cycles with the bit set keep the output high for N cycles (one per write).
- Other wdata bits are ignored. Writes to other addresses and cycles with xfc=0 produce no pulse.
- No read path; the register reads as 0 elsewhere in the register file.
- Both bits set in one write: both outputs pulse in the same cycle.
- Reset asserted mid-pulse: output drops at once. First edge after rst returns to 1 samples normally.
- Combinational inputs are not required to be stable while xfc=0.

Optional Feature:
- Macro: TRIG_GENERATOR_ALIGN_CHECK_EN.
- Defined: hit additionally requires address[1:0]==2'b00. Misaligned addresses never trigger, even if TRIG_ADDR itself is misaligned.
- Undefined: plain full-address compare as above.

Decomposition:
- Package trig_pkg holds:
  - TRIG_ADDR default constant.
  - Bit-index constants I2SI_OVR_BIT and I2SO_UDR_BIT.
  - Address/data width constants.
- Sub-module trig_pulse: one async-reset-low flop with a "fire" input. Instantiated twice, once per output. The top level holds only the decode.

Test Plan:
- Reset: hold rst=0 for 10 cycles with xfc toggling, address=12'h00C, wdata=8'hFF -> both outputs stay 0 throughout.
- Sweep: after reset, xfc=1 with address stepping 12'h000..12'h01C by 4 each cycle, wdata=8'hFF, then xfc=0 from 12'h020 -> each output high for exactly one cycle, the cycle after address 12'h00C is sampled; zero elsewhere.
- Selective bits:
  - wdata=8'h01 at 12'h00C -> only i2si pulse.
  - wdata=8'h02 -> only i2so pulse.
  - wdata=8'hFC -> no pulse.
- Strobe gating: address=12'h00C, wdata=8'hFF, xfc=0 -> no pulse. Same with xfc=1 at address=12'h10C -> no pulse (full compare).
- Back-to-back: two consecutive hits with wdata=8'h03 -> both outputs high for 2 cycles, then 0.
- Async reset mid-pulse: drop rst to 0 between edges while an output is 1 -> output reads 0 before the next clk edge. With TRIG_GENERATOR_ALIGN_CHECK_EN and TRIG_ADDR=12'h00D, a hit at 12'h00D -> no pulse.
